sram_controller: RTL and testbench

//   Sequences MEM-stage loads/stores onto an external 16-bit asynchronous SRAM. Each 32-bit access is split into two half-word phases.

---
 rtl/sram_controller_pkg.sv | 19 +
 rtl/sram_controller_if.sv | 25 ++
 rtl/sram_wait_counter.sv | 38 +++
 rtl/sram_controller.sv | 138 +++++++++++++
 tb/tb_sram_controller.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_controller_pkg.sv
// Shared constants and state encoding for the MEM-stage SRAM controller.
// Imported by the interface, the wait counter and the controller top.
package sram_controller_pkg;

    localparam int DATA_LEN         = 32;
    localparam int ADDR_LEN         = 32;
    localparam int SRAM_ADDR_LEN    = 18;
    localparam int SRAM_DATA_LEN    = 16;
    localparam int SRAM_BASE_ADDR   = 1024;
    localparam int SRAM_WAIT_CYCLES = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side bus between MEM stage (master) and SRAM controller (slave).
// Carries rd_en/wr_en/address/write_data requests and read_data/ready replies.
interface sram_controller_if
    import sram_controller_pkg::*;
#(
    parameter int DW = DATA_LEN,
    parameter int AW = ADDR_LEN
);
    logic          rd_en;
    logic          wr_en;
    logic [AW-1:0] address;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;
    logic          ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_wait_counter.sv
// Per-phase cycle counter with clear, enable and terminal-count flag.
// Ports: clk, rst (sync active-low), clr_i, en_i, cnt_o, tc_o (cnt==WAIT_CYCLES-1).
module sram_wait_counter
    import sram_controller_pkg::*;
#(
    parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES,
    parameter int CNT_W       = $clog2(WAIT_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == CNT_W'(WAIT_CYCLES - 1));
endmodule

// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit SRAM phases.
// Ports: clk, rst (sync active-low), bus (pipeline slave), SRAM address/data/oe/we_n pins.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int DATA_LEN_P    = DATA_LEN,
    parameter int ADDR_LEN_P    = ADDR_LEN,
    parameter int SRAM_AW       = SRAM_ADDR_LEN,
    parameter int SRAM_DW       = SRAM_DATA_LEN,
    parameter int BASE_ADDR     = SRAM_BASE_ADDR,
    parameter int WAIT_CYCLES   = SRAM_WAIT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);
    localparam int CNT_W = $clog2(WAIT_CYCLES);

    state_t                 state_q, state_d;
    logic [SRAM_AW-2:0]     hw_q, hw_d;
    logic [DATA_LEN_P-1:0]  wdata_q, wdata_d;
    logic                   wr_q, wr_d;
    logic [DATA_LEN_P-1:0]  rdata_q, rdata_d;

    logic                   cnt_clr;
    logic                   cnt_en;
    logic                   cnt_tc;
    logic [CNT_W-1:0]       cnt;
    logic                   in_phase;
    logic                   drive;

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .CNT_W       (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cnt),
        .tc_o  (cnt_tc)
    );

    // Word index relative to the base; the subtraction wraps and the cast
    // keeps only the half-word pair index that fits the SRAM.
    always_comb begin
        state_d = state_q;
        hw_d    = hw_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (bus.rd_en || bus.wr_en) begin
                    hw_d    = (SRAM_AW-1)'((bus.address
                              - ADDR_LEN_P'(BASE_ADDR)) >> 2);
                    wdata_d = bus.write_data;
                    wr_d    = bus.wr_en;
                    state_d = LOW;
                end
            end
            LOW: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    cnt_clr = 1'b1;
                    state_d = HIGH;
                    if (!wr_q) begin
                        rdata_d[SRAM_DW-1:0] = sram_dq_in;
                    end
                end
            end
            HIGH: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    cnt_clr = 1'b1;
                    state_d = DONE;
                    if (!wr_q) begin
                        rdata_d[DATA_LEN_P-1:SRAM_DW] = sram_dq_in;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            hw_q    <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            hw_q    <= hw_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    assign in_phase = (state_q == LOW) || (state_q == HIGH);
    assign drive    = in_phase && wr_q;

    // Write strobe releases on the last cycle of each phase so the SRAM
    // latches data while address and data are still held.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = drive;
        sram_we_n   = !(drive && !cnt_tc);
        if (in_phase) begin
            sram_addr = {hw_q, (state_q == HIGH)};
        end
        if (drive) begin
            sram_dq_out = (state_q == HIGH)
                        ? wdata_q[DATA_LEN_P-1:SRAM_DW]
                        : wdata_q[SRAM_DW-1:0];
        end
    end

    assign bus.read_data = rdata_q;
    assign bus.ready     = ((state_q == IDLE) && !bus.rd_en && !bus.wr_en)
                        || (state_q == DONE);
endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench: directed + random loads/stores against a word-level
// memory model, with a behavioural 16-bit SRAM written on we_n rise.
module tb_sram_controller;
    localparam int W      = 5;
    localparam int LAT    = 2 * W + 1;
    localparam int MEMSZ  = 262144;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    int checks = 0;
    int errors = 0;

    sram_controller_if bus ();

    sram_controller dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: combinational read, write captured on we_n rise.
    logic [15:0] sram_mem [0:MEMSZ-1];
    logic        prev_we = 1'b1;

    assign sram_dq_in = sram_mem[sram_addr];

    always @(negedge clk) begin
        if (!prev_we && sram_we_n && sram_dq_oe)
            sram_mem[sram_addr] <= sram_dq_out;
        prev_we <= sram_we_n;
    end

    // Reference model: half-word memory and last load result.
    bit [15:0]   ref_mem [int unsigned];
    logic [31:0] model_rd = '0;
    bit          pending_done = 1'b0;

    function automatic int unsigned hw_of(input logic [31:0] a);
        longint unsigned off;
        off = ({32'd0, a} + 64'h1_0000_0000 - 64'd1024) % 64'h1_0000_0000;
        return int'(((off / 4) * 2) % MEMSZ);
    endfunction

    function automatic bit [15:0] ref_rd(input int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input bit drop, input int gap);
        int          k;
        int          ph;
        int          pos;
        bit          is_st;
        int unsigned lo;
        is_st = wr;
        lo    = hw_of(a);
        bus.rd_en      = rd;
        bus.wr_en      = wr;
        bus.address    = a;
        bus.write_data = d;
        if (pending_done) @(negedge clk);
        #1;
        chk("ready_req", 32'(bus.ready), 32'd0);
        chk("we_n_req", 32'(sram_we_n), 32'd1);
        chk("oe_req", 32'(sram_dq_oe), 32'd0);
        k = 0;
        while (1) begin
            @(negedge clk);
            k++;
            if (bus.ready === 1'b1 || k >= 60) break;
            ph  = (k - 1) / W;
            pos = (k - 1) % W;
            chk("addr_phase", 32'(sram_addr), 32'(lo + ph));
            if (is_st) begin
                chk("oe_st", 32'(sram_dq_oe), 32'd1);
                chk("we_n_st", 32'(sram_we_n), 32'(pos == W - 1));
                chk("dq_out", 32'(sram_dq_out),
                    ph == 1 ? 32'(d[31:16]) : 32'(d[15:0]));
            end else begin
                chk("oe_ld", 32'(sram_dq_oe), 32'd0);
                chk("we_n_ld", 32'(sram_we_n), 32'd1);
            end
            if (drop && k == 2) begin
                bus.rd_en = 1'b0;
                bus.wr_en = 1'b0;
            end
        end
        chk("latency", 32'(k), 32'(LAT));
        if (is_st) begin
            ref_mem[lo]     = d[15:0];
            ref_mem[lo + 1] = d[31:16];
        end else begin
            model_rd = {ref_rd(lo + 1), ref_rd(lo)};
        end
        chk("rd_done", bus.read_data, model_rd);
        chk("we_n_done", 32'(sram_we_n), 32'd1);
        chk("oe_done", 32'(sram_dq_oe), 32'd0);
        pending_done = (gap == 0);
        if (gap > 0) begin
            bus.rd_en = 1'b0;
            bus.wr_en = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("ready_idle", 32'(bus.ready), 32'd1);
                chk("rd_idle", bus.read_data, model_rd);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MEMSZ; i++) sram_mem[i] = 16'h0000;
        bus.rd_en      = 1'b0;
        bus.wr_en      = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_rd", bus.read_data, 32'd0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq", 32'(sram_dq_out), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 1'b0, 2);
        chk("t2_sram0", 32'(sram_mem[0]), 32'h0000_BEEF);
        chk("t2_sram1", 32'(sram_mem[1]), 32'h0000_DEAD);
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 2);
        chk("t3_rd", bus.read_data, 32'hDEAD_BEEF);

        bus.rd_en      = 1'b0;
        bus.wr_en      = 1'b1;
        bus.address    = 32'd1100;
        bus.write_data = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        bus.wr_en = 1'b0;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            chk("t1_we_n", 32'(sram_we_n), 32'd1);
            chk("t1_oe", 32'(sram_dq_oe), 32'd0);
            chk("t1_ready", 32'(bus.ready), 32'd1);
            chk("t1_rd", bus.read_data, 32'd0);
        end
        model_rd = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("t1_ready_post", 32'(bus.ready), 32'd1);

        access(1'b0, 1'b1, 32'd1032, 32'h1234_5678, 1'b0, 0);
        access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, 2);
        chk("t4_rd", bus.read_data, 32'h1234_5678);
        chk("t4_sram4", 32'(sram_mem[4]), 32'h0000_5678);
        chk("t4_sram5", 32'(sram_mem[5]), 32'h0000_1234);

        access(1'b1, 1'b1, 32'd1028, 32'hA5A5_5A5A, 1'b0, 1);
        chk("t5_sram2", 32'(sram_mem[2]), 32'h0000_5A5A);
        chk("t5_sram3", 32'(sram_mem[3]), 32'h0000_A5A5);
        chk("t5_rd", bus.read_data, 32'h1234_5678);

        sram_mem[MEMSZ-1] = 16'h7777;
        access(1'b0, 1'b1, 32'd1020, 32'h0000_00FF, 1'b0, 1);
        chk("t6_lo", 32'(sram_mem[MEMSZ-2]), 32'h0000_00FF);
        chk("t6_hi", 32'(sram_mem[MEMSZ-1]), 32'h0000_0000);
        chk("t6_nox", 32'(^{bus.read_data, bus.ready, sram_addr,
                            sram_dq_out, sram_dq_oe, sram_we_n} === 1'bx),
            32'd0);
        access(1'b1, 1'b0, 32'd1020, 32'h0, 1'b0, 1);
        chk("t6_rd", bus.read_data, 32'h0000_00FF);

        for (int n = 0; n < 60; n++) begin
            int          op;
            logic [31:0] a;
            op = int'($urandom_range(0, 2));
            a  = 32'd1008 + 32'(4 * $urandom_range(0, 35));
            access(op != 1, op != 0, a, 32'($urandom),
                   $urandom_range(0, 4) == 0, int'($urandom_range(0, 3)));
        end
        if (pending_done) begin
            bus.rd_en = 1'b0;
            bus.wr_en = 1'b0;
            @(negedge clk);
        end

        foreach (ref_mem[k])
            chk("mem_final", 32'(sram_mem[k]), 32'(ref_mem[k]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
